// File: rtl/input_periph_pkg.sv
// Shared constants and address decode for the memory-mapped input peripheral.
package input_periph_pkg;

  localparam int SW_W    = 18;
  localparam int KEY_W   = 4;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;

  localparam logic [ADDR_W-1:0] IN_SW_ADDR     = 6'h00;
  localparam logic [ADDR_W-1:0] IN_KEY_ADDR    = 6'h01;
  localparam logic [ADDR_W-1:0] IN_KFLAG_ADDR  = 6'h02;
  localparam logic [ADDR_W-1:0] IN_SWFLAG_ADDR = 6'h03;

  typedef enum logic [2:0] {
    SEL_SW,
    SEL_KEY,
    SEL_KFLAG,
    SEL_SWFLAG,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] a);
    reg_sel_e sel;
    case (a)
      IN_SW_ADDR:     sel = SEL_SW;
      IN_KEY_ADDR:    sel = SEL_KEY;
      IN_KFLAG_ADDR:  sel = SEL_KFLAG;
      IN_SWFLAG_ADDR: sel = SEL_SWFLAG;
      default:        sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/input_periph_if.sv
// Load/store bus between the core and the input peripheral.
interface input_periph_if;
  logic [5:0]  addr;
  logic        st_en;
  logic [31:0] st_data;
  logic [31:0] out;

  modport master (output addr, output st_en, output st_data, input out);
  modport slave  (input addr, input st_en, input st_data, output out);
endinterface

// File: rtl/key_debounce.sv
// One-key debouncer: the level only follows the synced input after
// DB_CYCLES consecutive edges of disagreement.
module key_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic lvl,
  output logic rise
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    flip  = 1'b0;
    if (sync_in != lvl_q) begin
      if (cnt_q == CNT_MAX) begin
        flip  = 1'b1;
        lvl_d = sync_in;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Rise is reported on the same edge the level commits, so the flag
    // register can set in lockstep with lvl.
    rise = flip & sync_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = lvl_q;

endmodule

// File: rtl/input_periph.sv
// Switch/button input peripheral: 2-flop synchronizers, per-key debounce,
// sticky W1C event flags and a combinational read mux.
module input_periph
  import input_periph_pkg::*;
#(
  parameter int DB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  i_sw,
  input  logic [KEY_W-1:0] i_key,
  input_periph_if.slave    bus
);

  logic [SW_W-1:0]  sw_s1_q, sw_s1_d;
  logic [SW_W-1:0]  sw_sync_q, sw_sync_d;
  logic [SW_W-1:0]  sw_prev_q, sw_prev_d;
  logic [KEY_W-1:0] key_s1_q, key_s1_d;
  logic [KEY_W-1:0] key_sync_q, key_sync_d;
  logic [KEY_W-1:0] kflag_q, kflag_d;
  logic             swflag_q, swflag_d;

  logic [KEY_W-1:0] key_lvl;
  logic [KEY_W-1:0] key_rise;
  logic [KEY_W-1:0] kflag_clr;
  logic             swflag_clr;
  logic             sw_chg;
  reg_sel_e         sel;

  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .rst     (rst),
      .sync_in (key_sync_q[k]),
      .lvl     (key_lvl[k]),
      .rise    (key_rise[k])
    );
  end

  always_comb begin
    sel        = decode_addr(bus.addr);
    // Buttons are active-low on the board; everything past here is 1 = pressed.
    sw_s1_d    = i_sw;
    sw_sync_d  = sw_s1_q;
    sw_prev_d  = sw_sync_q;
    key_s1_d   = ~i_key;
    key_sync_d = key_s1_q;

    kflag_clr  = (bus.st_en && sel == SEL_KFLAG) ? bus.st_data[KEY_W-1:0] : '0;
    swflag_clr = bus.st_en && sel == SEL_SWFLAG && bus.st_data[0];
    sw_chg     = sw_sync_q != sw_prev_q;

    // Set terms are OR'd in after the clear so a same-edge event is never lost.
    kflag_d    = (kflag_q & ~kflag_clr) | key_rise;
    swflag_d   = (swflag_q & ~swflag_clr) | sw_chg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_s1_q    <= '0;
      sw_sync_q  <= '0;
      sw_prev_q  <= '0;
      key_s1_q   <= '0;
      key_sync_q <= '0;
      kflag_q    <= '0;
      swflag_q   <= 1'b0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_sync_q  <= sw_sync_d;
      sw_prev_q  <= sw_prev_d;
      key_s1_q   <= key_s1_d;
      key_sync_q <= key_sync_d;
      kflag_q    <= kflag_d;
      swflag_q   <= swflag_d;
    end
  end

  always_comb begin
    bus.out = '0;
    case (sel)
      SEL_SW:     bus.out = {{(DATA_W-SW_W){1'b0}}, sw_sync_q};
      SEL_KEY:    bus.out = {{(DATA_W-KEY_W){1'b0}}, key_lvl};
      SEL_KFLAG:  bus.out = {{(DATA_W-KEY_W){1'b0}}, kflag_q};
      SEL_SWFLAG: bus.out = {{(DATA_W-1){1'b0}}, swflag_q};
      default:    bus.out = '0;
    endcase
  end

endmodule

// File: tb/tb_input_periph.sv
// Directed bench for input_periph with a history-based reference model.
module tb_input_periph;
  import input_periph_pkg::*;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] i_sw;
  logic [3:0]  i_key;

  input_periph_if bus();

  input_periph #(.DB_CYCLES(DB)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_sw  (i_sw),
    .i_key (i_key),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Model: raw samples per edge; sync = sample from one edge earlier than the newest.
  logic [17:0]   m_sw [3];
  logic [3:0]    m_key[2];
  logic [3:0]    m_lvl;
  logic [3:0]    m_kflag;
  logic          m_swflag;
  logic [DB-1:0] m_win[4];
  int            m_since[4];

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      IN_SW_ADDR:     r = {14'b0, m_sw[1]};
      IN_KEY_ADDR:    r = {28'b0, m_lvl};
      IN_KFLAG_ADDR:  r = {28'b0, m_kflag};
      IN_SWFLAG_ADDR: r = {31'b0, m_swflag};
      default:        r = '0;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    logic [3:0] rise;
    logic       sw_set;
    rise = '0;
    if (!rst) begin
      for (int i = 0; i < 3; i++) m_sw[i] = '0;
      m_key[0] = '0;
      m_key[1] = '0;
      m_lvl = '0;
      m_kflag = '0;
      m_swflag = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_win[k] = '0;
        m_since[k] = 0;
      end
    end else begin
      // A key level flips once the last DB sampled sync values all disagree with it.
      for (int k = 0; k < 4; k++) begin
        m_win[k] = {m_win[k][DB-2:0], m_key[1][k]};
        m_since[k]++;
        if (m_since[k] >= DB && m_win[k] == {DB{~m_lvl[k]}}) begin
          m_lvl[k] = ~m_lvl[k];
          m_since[k] = 0;
          rise[k] = m_lvl[k];
        end
      end
      sw_set = m_sw[1] != m_sw[2];
      if (bus.st_en && bus.addr == IN_KFLAG_ADDR) m_kflag = m_kflag & ~bus.st_data[3:0];
      m_kflag = m_kflag | rise;
      if (bus.st_en && bus.addr == IN_SWFLAG_ADDR && bus.st_data[0]) m_swflag = 1'b0;
      if (sw_set) m_swflag = 1'b1;
      m_sw[2]  = m_sw[1];
      m_sw[1]  = m_sw[0];
      m_sw[0]  = i_sw;
      m_key[1] = m_key[0];
      m_key[0] = ~i_key;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (bus.out !== model_read(bus.addr)) begin
        failures++;
        $display("FAIL model_cmp t=%0t addr=%0h got=%h exp=%h", $time, bus.addr, bus.out,
                 model_read(bus.addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    bus.st_en = 1'b0;
  endtask

  task automatic store(input logic [5:0] a, input logic [31:0] d);
    bus.addr    = a;
    bus.st_data = d;
    bus.st_en   = 1'b1;
    tick();
  endtask

  task automatic peek(input logic [5:0] a, input logic [31:0] exp, input string name);
    bus.addr = a;
    #1;
    checks++;
    if (bus.out !== exp) begin
      failures++;
      $display("FAIL %s addr=%0h got=%h exp=%h", name, a, bus.out, exp);
    end
  endtask

  initial begin
    i_sw        = 18'h3FFFF;
    i_key       = 4'h0;
    bus.addr    = '0;
    bus.st_en   = 1'b0;
    bus.st_data = '0;
    rst         = 1'b0;

    // Reset with switches up and all buttons pressed
    tick();
    chk_on = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) peek(6'(a), 32'h0, "reset_zero");
    rst = 1'b1;
    tick();
    peek(IN_SW_ADDR, 32'h0, "sw_1edge");
    tick();
    peek(IN_SW_ADDR, 32'h3FFFF, "sw_2edge");
    i_key = 4'hF;
    repeat (8) tick();
    peek(IN_SWFLAG_ADDR, 32'h1, "swflag_after_reset");
    peek(IN_KEY_ADDR, 32'h0, "lvl_idle");
    peek(IN_KFLAG_ADDR, 32'h0, "kflag_idle");

    // Debounced press and release of key 0
    i_key = 4'b1110;
    repeat (5) tick();
    peek(IN_KEY_ADDR, 32'h0, "press_edge5");
    tick();
    peek(IN_KEY_ADDR, 32'h1, "press_edge6");
    peek(IN_KFLAG_ADDR, 32'h1, "kflag_press");
    i_key = 4'hF;
    repeat (5) tick();
    peek(IN_KEY_ADDR, 32'h1, "release_edge5");
    tick();
    peek(IN_KEY_ADDR, 32'h0, "release_edge6");
    peek(IN_KFLAG_ADDR, 32'h1, "kflag_after_release");

    // Glitch on key 2 shorter than DB
    i_key = 4'b1011;
    repeat (3) tick();
    i_key = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      peek(IN_KEY_ADDR, 32'h0, "glitch_lvl");
      peek(IN_KFLAG_ADDR, 32'h1, "glitch_kflag");
    end

    // Keys 1 and 3 rise on the same edge that a W1C of bit 1 lands
    i_key = 4'b0101;
    repeat (5) tick();
    peek(IN_KFLAG_ADDR, 32'h1, "pre_collision");
    store(IN_KFLAG_ADDR, 32'h2);
    peek(IN_KFLAG_ADDR, 32'hB, "collision_set_wins");
    peek(IN_KEY_ADDR, 32'hA, "collision_lvl");

    // W1C and ignored stores
    store(IN_KFLAG_ADDR, 32'h9);
    peek(IN_KFLAG_ADDR, 32'h2, "w1c_mask9");
    store(6'h05, 32'hF);
    peek(IN_KFLAG_ADDR, 32'h2, "store_other_addr");
    peek(IN_SWFLAG_ADDR, 32'h1, "swflag_kept");
    peek(6'h05, 32'h0, "unmapped_05");
    peek(6'h3F, 32'h0, "unmapped_3f");

    // Switch change flag
    store(IN_SWFLAG_ADDR, 32'h1);
    peek(IN_SWFLAG_ADDR, 32'h0, "swflag_clr");
    i_sw = 18'h3FF7F;
    tick();
    tick();
    peek(IN_SWFLAG_ADDR, 32'h0, "swflag_2edge");
    peek(IN_SW_ADDR, 32'h3FF7F, "sw_toggle");
    tick();
    peek(IN_SWFLAG_ADDR, 32'h1, "swflag_3edge");
    store(IN_SWFLAG_ADDR, 32'h1);
    peek(IN_SWFLAG_ADDR, 32'h0, "swflag_clr2");
    for (int i = 0; i < 5; i++) begin
      tick();
      peek(IN_SWFLAG_ADDR, 32'h0, "swflag_static");
    end

    // Reset in the middle of a debounce; key must requalify from scratch
    i_key = 4'hF;
    repeat (6) tick();
    peek(IN_KEY_ADDR, 32'h0, "all_released");
    i_key = 4'b1110;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    peek(IN_KFLAG_ADDR, 32'h0, "mid_reset_kflag");
    repeat (5) tick();
    peek(IN_KEY_ADDR, 32'h0, "requal_edge5");
    tick();
    peek(IN_KEY_ADDR, 32'h1, "requal_edge6");
    peek(IN_KFLAG_ADDR, 32'h1, "requal_kflag");

    tick();
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
